// File: rtl/pipe_pkg.sv
// Shared types and defaults for the skid-buffered pipeline stage.
// Holds the occupancy state encoding and the default payload/counter widths.
package pipe_pkg;

  localparam int DEFAULT_DATA_W = 73;
  localparam int DEFAULT_CNT_W  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  function automatic logic [1:0] occupancy_of(state_e s);
    case (s)
      EMPTY:   return 2'd0;
      ONE:     return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Upstream/downstream valid-ready handshake of the skid stage.
// The stage itself is the slave; the producer/consumer side is the master.
interface pipe_skid_stage_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;

  modport master (
    output in_valid_i,
    output in_data_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  out_data_o
  );

  modport slave (
    input  in_valid_i,
    input  in_data_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output out_data_o
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc_i high and sticks at all-ones.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int W = DEFAULT_CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (inc_i && (cnt_reg != {W{1'b1}})) begin
      cnt_next = cnt_reg + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt_o = cnt_reg;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid stage (main + skid register) with registered ready, flush
// and a saturating count of downstream stall cycles.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                flush_i,
  pipe_skid_stage_if.slave    bus,
  output logic [1:0]          occupancy_o,
  output logic [CNT_W-1:0]    stall_cnt_o
);

  state_e            state_reg;
  state_e            state_next;
  logic [DATA_W-1:0] main_reg;
  logic [DATA_W-1:0] skid_reg;

  logic in_ready;
  logic out_valid;
  logic accept;
  logic fire;
  logic load_main;
  logic load_skid;
  logic move_skid;
  logic stall_inc;

  // ready/valid are pure state decodes, so no input reaches them combinationally
  assign accept = bus.in_valid_i & in_ready;
  assign fire   = out_valid & bus.out_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    if (flush_i) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            load_main  = 1'b1;
            state_next = ONE;
          end
        end
        ONE: begin
          if (accept && fire) begin
            load_main  = 1'b1;
          end else if (accept) begin
            load_skid  = 1'b1;
            state_next = FULL;
          end else if (fire) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (fire) begin
            move_skid  = 1'b1;
            state_next = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready    = (state_reg != FULL);
    out_valid   = (state_reg != EMPTY);
    occupancy_o = occupancy_of(state_reg);
  end

  // Payload registers keep their contents across a flush; only the state empties.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_reg <= '0;
      skid_reg <= '0;
    end else begin
      if (load_main) begin
        main_reg <= bus.in_data_i;
      end else if (move_skid) begin
        main_reg <= skid_reg;
      end
      if (load_skid) begin
        skid_reg <= bus.in_data_i;
      end
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = main_reg;

  assign stall_inc = out_valid & ~bus.out_ready_i;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (stall_inc),
    .cnt_o   (stall_cnt_o)
  );

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter DATA_W, default 73, SHALL set the payload width (wb 2 + mem 2 + result 32 + rtdata 32 + writeaddr 5).
REQ-002 Parameter CNT_W, default 16, SHALL set the stall-counter width.
REQ-003 clk_i  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst_n_i  input  1  reset; asynchronous, active-low.
REQ-005 flush_i  input  1  synchronous flush that empties the stage.
REQ-006 in_valid_i  input  1  upstream payload valid.
REQ-007 in_ready_o  output  1  stage can accept a payload this cycle.
REQ-008 in_data_i  input  DATA_W  upstream payload.
REQ-009 out_valid_o  output  1  stage holds a payload for downstream.
REQ-010 out_ready_i  input  1  downstream accepts the payload (0 = memory stall).
REQ-011 out_data_o  output  DATA_W  payload presented downstream.
REQ-012 occupancy_o  output  2  number of held entries, 0..2.
REQ-013 stall_cnt_o  output  CNT_W  cycles with out_valid_o=1 and out_ready_i=0, saturating.

Function
REQ-014 The stage SHALL hold two entries: a main register driving out_data_o and a skid register.
REQ-015 States SHALL be EMPTY, ONE and FULL, with occupancy_o = 0, 1 and 2 respectively.
REQ-016 in_ready_o SHALL be 1 in EMPTY and ONE and 0 in FULL, decoded from state only, with no combinational path from any input.
REQ-017 out_valid_o SHALL be 1 in ONE and FULL, and out_data_o SHALL always equal the main register.
REQ-018 An accept SHALL occur when in_valid_i & in_ready_o, and a fire when out_valid_o & out_ready_i.
REQ-019 In EMPTY, an accept SHALL load main and go to ONE; otherwise the stage SHALL stay in EMPTY.
REQ-020 In ONE, accept with fire SHALL load main and stay in ONE, giving one-cycle latency and full throughput.
REQ-021 In ONE, accept without fire SHALL load skid and go to FULL.
REQ-022 In ONE, fire without accept SHALL go to EMPTY; with neither, the stage SHALL stay in ONE.
REQ-023 In FULL, fire SHALL copy skid to main and go to ONE; otherwise the stage SHALL stay in FULL. No accept is possible in FULL.
REQ-024 Payload order SHALL be preserved; no payload SHALL be dropped or duplicated except by flush.
REQ-025 While out_ready_i=0, main, skid and out_data_o SHALL hold their values.
REQ-026 flush_i=1 SHALL take priority over all other events: next state EMPTY, and any accept or fire in that cycle is discarded.
REQ-027 A flush SHALL leave the data registers unchanged and SHALL NOT change stall_cnt_o.
REQ-028 stall_cnt_o SHALL increment by 1 in each cycle where out_valid_o=1 and out_ready_i=0, including a flush cycle.
REQ-029 stall_cnt_o SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-030 All outputs SHALL be glitch-free register or state decodes.

Reset
REQ-031 While rst_n_i=0: state EMPTY, main=0, skid=0, stall_cnt_o=0, out_valid_o=0, in_ready_o=1, occupancy_o=0.
REQ-032 Reset asserted mid-operation SHALL discard held payloads immediately, without waiting for a clock edge.
REQ-033 After rst_n_i rises, the first rising clock edge SHALL already be able to accept a payload.

Structure
REQ-034 A shared package pipe_pkg SHALL hold the state enumeration (EMPTY/ONE/FULL) and the default DATA_W and CNT_W constants.
REQ-035 The saturating counter SHALL be the sub-module sat_counter (parameter W; ports clk_i, rst_n_i, inc_i, cnt_o).
REQ-036 The FSM and data registers SHALL reside in pipe_skid_stage; no other sub-modules.

Verification
REQ-037 Reset, then in_valid_i=1 with data 0x1 in cycle 0 and 0x2 in cycle 1, out_ready_i=1 -> out_data_o=0x1 after edge 1, 0x2 after edge 2, occupancy_o=1 throughout.
REQ-038 out_ready_i=0, push 0xA then 0xB -> occupancy_o=2, in_ready_o=0; raise out_ready_i -> out shows 0xA then 0xB; stall_cnt_o equals the number of stalled cycles.
REQ-039 FULL with 0xA/0xB, flush_i=1 together with in_valid_i=1 (0xC) and out_ready_i=1 -> next cycle EMPTY, out_valid_o=0, and 0xC is never emitted.
REQ-040 CNT_W=3, out_valid_o=1, out_ready_i=0 for 10 cycles -> stall_cnt_o reaches 7 and holds 7.
REQ-041 rst_n_i dropped between edges while FULL -> out_valid_o=0, in_ready_o=1, occupancy_o=0 immediately; the first payload after release is accepted on the first edge.
REQ-042 Random valid/ready streams of 1000 payloads, checked against a scoreboard -> in-order, lossless, no duplicates, with in_ready_o=0 only in FULL.
